// File: rtl/reg_file_if.sv
// Register-file bus: two operand read ports, one writeback port and a debug read port.
// The datapath side is the master; the register file is the slave.
interface reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [WIDTH-1:0]  rd_data1;
    logic [WIDTH-1:0]  rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] dbg_addr;
    logic [WIDTH-1:0]  dbg_data;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dbg_addr,
        input  rd_data1, rd_data2, dbg_data
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dbg_addr,
        output rd_data1, rd_data2, dbg_data
    );
endinterface

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports, one clocked write port,
// hardwired zero register, optional write-to-read bypass and an unbypassed debug port.
module reg_file #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input logic        clk,
    input logic        rst_n,
    reg_file_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] r_regs   [1:DEPTH-1];
    logic [WIDTH-1:0] w_stored [DEPTH];
    logic [DEPTH-1:0] w_wrSel;
    logic             w_wrActive;
    logic             w_hit1;
    logic             w_hit2;

    // Writes to entry 0 are dropped by never decoding it.
    assign w_wrActive = bus.wr_en && (bus.wr_addr != '0);

    genvar g;
    generate
        for (g = 1; g < DEPTH; g++) begin : g_entry
            assign w_wrSel[g] = w_wrActive && (bus.wr_addr == ADDR_W'(g));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_regs[g] <= '0;
                end else if (w_wrSel[g]) begin
                    r_regs[g] <= bus.wr_data;
                end
            end
        end
    endgenerate

    assign w_wrSel[0] = 1'b0;

    always_comb begin
        w_stored[0] = '0;
        for (int i = 1; i < DEPTH; i++) begin
            w_stored[i] = r_regs[i];
        end
    end

    // Bypass is qualified by rst_n so every read is zero while reset is held.
    assign w_hit1 = (BYPASS != 0) && rst_n && w_wrActive && (bus.wr_addr == bus.rd_addr1);
    assign w_hit2 = (BYPASS != 0) && rst_n && w_wrActive && (bus.wr_addr == bus.rd_addr2);

    assign bus.rd_data1 = (bus.rd_addr1 == '0) ? '0 :
                          w_hit1               ? bus.wr_data :
                                                 w_stored[bus.rd_addr1];

    assign bus.rd_data2 = (bus.rd_addr2 == '0) ? '0 :
                          w_hit2               ? bus.wr_data :
                                                 w_stored[bus.rd_addr2];

    assign bus.dbg_data = w_stored[bus.dbg_addr];
endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: drives a bypassing and a non-bypassing instance with identical stimulus
// and checks both against an array model of the architectural register state.
module tb_reg_file;
    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic clk;
    logic rst_n;

    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic [WIDTH-1:0]  wrData;
    logic [ADDR_W-1:0] rdAddr1;
    logic [ADDR_W-1:0] rdAddr2;
    logic [ADDR_W-1:0] dbgAddr;

    logic [WIDTH-1:0] model [DEPTH];
    logic [WIDTH-1:0] aluOut;

    int vectors;
    int miscompares;

    reg_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) ifB ();
    reg_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) ifN ();

    assign ifB.rd_addr1 = rdAddr1;
    assign ifB.rd_addr2 = rdAddr2;
    assign ifB.wr_en    = wrEn;
    assign ifB.wr_addr  = wrAddr;
    assign ifB.wr_data  = wrData;
    assign ifB.dbg_addr = dbgAddr;
    assign ifN.rd_addr1 = rdAddr1;
    assign ifN.rd_addr2 = rdAddr2;
    assign ifN.wr_en    = wrEn;
    assign ifN.wr_addr  = wrAddr;
    assign ifN.wr_data  = wrData;
    assign ifN.dbg_addr = dbgAddr;

    reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(1)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB.slave)
    );

    reg_file #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(0)) dutN (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifN.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] expRead(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (!rst_n) return '0;
        if (byp && wrEn && (wrAddr == a)) return wrData;
        return model[a];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic compare(input string tag, input logic [WIDTH-1:0] obs,
                           input logic [WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, " B.rd1"}, ifB.rd_data1, expRead(rdAddr1, 1'b1));
        compare({tag, " B.rd2"}, ifB.rd_data2, expRead(rdAddr2, 1'b1));
        compare({tag, " B.dbg"}, ifB.dbg_data, model[dbgAddr]);
        compare({tag, " N.rd1"}, ifN.rd_data1, expRead(rdAddr1, 1'b0));
        compare({tag, " N.rd2"}, ifN.rd_data2, expRead(rdAddr2, 1'b0));
        compare({tag, " N.dbg"}, ifN.dbg_data, model[dbgAddr]);
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [WIDTH-1:0] wd, input logic [ADDR_W-1:0] a1,
                                 input logic [ADDR_W-1:0] a2, input logic [ADDR_W-1:0] da);
        wrEn    = we;
        wrAddr  = wa;
        wrData  = wd;
        rdAddr1 = a1;
        rdAddr2 = a2;
        dbgAddr = da;
        #1;
    endtask

    // One clock edge; the model commits the write the DUT sees at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wrEn && (wrAddr != 0)) model[wrAddr] = wrData;
        @(negedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clearModel();
        applyStimulus(1'b1, 5'd3, 32'h1234_5678, 5'd3, 5'd0, 5'd3);
        checkOutput("reset-held");
        tick();
        checkOutput("reset-held-edge");
        rst_n = 1'b1;
        #1;

        // Fill every register with nonzero data.
        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b1, ADDR_W'(i), $urandom() | 32'h1, ADDR_W'(i), ADDR_W'(i - 1),
                          ADDR_W'(i - 1));
            checkOutput("fill");
            tick();
        end
        applyStimulus(1'b0, 5'd0, '0, 5'd31, 5'd17, 5'd9);
        checkOutput("filled");

        // Reset pulse between edges clears everything immediately.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clearModel();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 5'd0, '0, ADDR_W'(i), ADDR_W'(DEPTH - 1 - i), ADDR_W'(i));
            checkOutput("async-reset");
        end
        rst_n = 1'b1;
        #1;

        applyStimulus(1'b1, 5'd8, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd8);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd8, 5'd0, 5'd8);
        compare("wr8 rd1", ifB.rd_data1, 32'hDEAD_BEEF);
        compare("wr8 dbg", ifN.dbg_data, 32'hDEAD_BEEF);
        checkOutput("wr8");

        applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
        checkOutput("zero-pre");
        tick();
        checkOutput("zero-post");
        compare("zero rd1", ifB.rd_data1, 32'h0);

        applyStimulus(1'b1, 5'd5, 32'h1, 5'd0, 5'd0, 5'd5);
        tick();
        applyStimulus(1'b1, 5'd5, 32'h42, 5'd5, 5'd5, 5'd5);
        compare("bypass B.rd2", ifB.rd_data2, 32'h42);
        compare("bypass N.rd2", ifN.rd_data2, 32'h1);
        compare("bypass dbg", ifB.dbg_data, 32'h1);
        checkOutput("bypass-pre");
        tick();
        compare("bypass N.rd2 post", ifN.rd_data2, 32'h42);
        checkOutput("bypass-post");

        applyStimulus(1'b0, 5'd9, 32'h55, 5'd9, 5'd9, 5'd9);
        tick();
        checkOutput("wr-gated");
        rst_n = 1'b0;
        clearModel();
        applyStimulus(1'b1, 5'd9, 32'h55, 5'd9, 5'd9, 5'd9);
        tick();
        checkOutput("wr-in-reset");
        wrEn  = 1'b0;
        rst_n = 1'b1;
        #1;
        compare("wr-in-reset dbg9", ifB.dbg_data, 32'h0);
        checkOutput("reset-released");

        // ALU hookup: subtract operands, write the result back to r3.
        applyStimulus(1'b1, 5'd1, 32'd7, 5'd0, 5'd0, 5'd1);
        tick();
        applyStimulus(1'b1, 5'd2, 32'd5, 5'd0, 5'd0, 5'd2);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd1, 5'd2, 5'd0);
        checkOutput("alu-operands");
        aluOut = model[1] - model[2];
        applyStimulus(1'b1, 5'd3, aluOut, 5'd1, 5'd2, 5'd3);
        tick();
        applyStimulus(1'b0, 5'd0, '0, 5'd1, 5'd2, 5'd3);
        compare("alu r3", ifB.dbg_data, 32'd2);
        checkOutput("alu-writeback");

        // Random traffic with frequent read/write address collisions.
        for (int n = 0; n < 400; n++) begin
            logic [ADDR_W-1:0] wa;
            wa = ADDR_W'($urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                clearModel();
            end else begin
                rst_n = 1'b1;
            end
            applyStimulus($urandom_range(0, 1) == 1, wa, $urandom(),
                          ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1)),
                          ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1)),
                          ($urandom_range(0, 2) == 0) ? wa : ADDR_W'($urandom_range(0, DEPTH - 1)));
            checkOutput("random");
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
